fact_cu: RTL and testbench

Control unit for the iterative factorial datapath: sequences the down-counter, multiplier, result mux, result register and output buffer, using the datapath's counter-greater-than-one flag to decide when to stop. It sits between the requesting logic (GO/N, DONE/ERR handshake) and the datapath control pins (MUX, REG_LD, CNT_EN, CNT_LD, DONE), forming the factorial top level together with the datapath.

---
 rtl/fact_pkg.sv | 32 +++
 rtl/fact_cu_dec.sv | 45 ++++
 rtl/fact_cu.sv | 104 ++++++++++
 tb/tb_fact_cu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared definitions for the iterative factorial control unit and the
// factorial top level.
//   state_t      : FSM state encoding, also driven on the CS debug port
//   FACT_MAX_N   : largest N whose factorial fits in 32 bits
//   CV_*         : bit positions in the control vector that the decoder
//                  produces and the top level fans out to the datapath pins
// -----------------------------------------------------------------------------
package fact_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_MULT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int FACT_MAX_N = 12;

    // Control vector layout
    localparam int CV_CNT_LD = 0;
    localparam int CV_CNT_EN = 1;
    localparam int CV_MUX    = 2;
    localparam int CV_REG_LD = 3;
    localparam int CV_DONE   = 4;
    localparam int CV_ERR    = 5;
    localparam int CV_W      = 6;

endpackage

// File: rtl/fact_cu_dec.sv
// -----------------------------------------------------------------------------
// fact_cu_dec
// Pure combinational decoder from the registered FSM state to the datapath
// control vector (Moore outputs).
//   state : current FSM state
//   ctrl  : control vector, bit positions CV_* from fact_pkg
// Build option: FACT_ERR_EN -- when defined, the ERROR state drives the ERR
// bit; otherwise ERR is never asserted.
// -----------------------------------------------------------------------------
module fact_cu_dec
    import fact_pkg::*;
(
    input  state_t            state,
    output logic [CV_W-1:0]   ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_LOAD: begin
                // counter <= N, register <= 1
                ctrl[CV_CNT_LD] = 1'b1;
                ctrl[CV_MUX]    = 1'b1;
                ctrl[CV_REG_LD] = 1'b1;
            end
            ST_MULT: begin
                // register <= register * count, count--
                ctrl[CV_REG_LD] = 1'b1;
                ctrl[CV_CNT_EN] = 1'b1;
            end
            ST_DONE: begin
                ctrl[CV_DONE] = 1'b1;
            end
`ifdef FACT_ERR_EN
            ST_ERROR: begin
                ctrl[CV_ERR] = 1'b1;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/fact_cu.sv
// -----------------------------------------------------------------------------
// fact_cu
// Control unit for the iterative factorial datapath. Sequences counter load,
// result-register init, and CHECK/MULT iterations until the datapath reports
// the counter is no longer greater than one.
// Ports:
//   CLK, RST : rising-edge clock, asynchronous active-high reset
//   GO, N    : request level and operand
//   GT       : datapath flag, counter value > 1
//   CNT_LD, CNT_EN, MUX, REG_LD, DONE, ERR : datapath/handshake controls
//   CS       : current state encoding (debug)
// Build option: FACT_ERR_EN -- when defined, requests with N > MAX_N go to
// the ERROR state instead of being computed.
//
// Handshake: GO is a level. It is accepted only in IDLE (N sampled on that
// same edge). The FSM then runs to completion regardless of GO. DONE (or ERR)
// holds while GO stays high and the FSM returns to IDLE on the first edge
// that sees GO low, so a new request needs at least one IDLE cycle.
// -----------------------------------------------------------------------------
module fact_cu
    import fact_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MAX_N = FACT_MAX_N
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GO,
    input  logic [WIDTH-1:0] N,
    input  logic             GT,
    output logic             CNT_LD,
    output logic             CNT_EN,
    output logic             MUX,
    output logic             REG_LD,
    output logic             DONE,
    output logic             ERR,
    output logic [2:0]       CS
);

    state_t           state;
    state_t           state_nxt;
    logic [CV_W-1:0]  ctrl;
    logic             n_too_big;

`ifdef FACT_ERR_EN
    localparam logic [WIDTH-1:0] MAX_N_W = WIDTH'(MAX_N);
    // Unsigned compare over the full operand width
    assign n_too_big = (N > MAX_N_W);
`else
    logic unused_cfg;
    assign n_too_big  = 1'b0;
    assign unused_cfg = (^N) ^ (MAX_N > 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (GO) begin
                    state_nxt = n_too_big ? ST_ERROR : ST_LOAD;
                end
            end
            ST_LOAD:  state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = GT ? ST_MULT : ST_DONE;
            ST_MULT:  state_nxt = ST_CHECK;
            ST_DONE: begin
                if (!GO) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef FACT_ERR_EN
            ST_ERROR: begin
                if (!GO) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            // Unused encodings recover to IDLE
            default:  state_nxt = ST_IDLE;
        endcase
    end

    fact_cu_dec u_dec (
        .state (state),
        .ctrl  (ctrl)
    );

    assign CNT_LD = ctrl[CV_CNT_LD];
    assign CNT_EN = ctrl[CV_CNT_EN];
    assign MUX    = ctrl[CV_MUX];
    assign REG_LD = ctrl[CV_REG_LD];
    assign DONE   = ctrl[CV_DONE];
    assign ERR    = ctrl[CV_ERR];
    assign CS     = state;

endmodule

// File: tb/tb_fact_cu.sv
// -----------------------------------------------------------------------------
// tb_fact_cu
// Directed bench for fact_cu with a small behavioural factorial datapath
// (down-counter, result register) so that result values can be checked.
// Cycle numbering: edge k is the clock edge that first samples GO high;
// "cycle k+c" is observed on the falling edge after the c-th rising edge
// counted from edge k.
// -----------------------------------------------------------------------------
module tb_fact_cu;

    logic        CLK;
    logic        RST;
    logic        GO;
    logic [31:0] N;
    logic        GT;
    logic        CNT_LD;
    logic        CNT_EN;
    logic        MUX;
    logic        REG_LD;
    logic        DONE;
    logic        ERR;
    logic [2:0]  CS;

    int n_checks;
    int n_fail;

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    fact_cu dut (
        .CLK    (CLK),
        .RST    (RST),
        .GO     (GO),
        .N      (N),
        .GT     (GT),
        .CNT_LD (CNT_LD),
        .CNT_EN (CNT_EN),
        .MUX    (MUX),
        .REG_LD (REG_LD),
        .DONE   (DONE),
        .ERR    (ERR),
        .CS     (CS)
    );

    // ---------------- datapath model ----------------
    logic [31:0] dp_cnt;
    logic [31:0] dp_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dp_cnt <= '0;
            dp_reg <= '0;
        end else begin
            if (CNT_LD) dp_cnt <= N;
            else if (CNT_EN) dp_cnt <= dp_cnt - 32'd1;
            if (REG_LD) dp_reg <= MUX ? 32'd1 : dp_reg * dp_cnt;
        end
    end

    assign GT = (dp_cnt > 32'd1);

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b0;
        GO  = 1'b0;
        N   = '0;
        #3;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({CNT_LD, CNT_EN, MUX, REG_LD, DONE, ERR} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {CNT_LD, CNT_EN, MUX, REG_LD, DONE, ERR});
        end
        n_checks++;
        if (CS !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cs: got %0d want 0", CS);
        end
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (CS !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_hold_cs: got %0d want 0", CS);
        end
        RST = 1'b0;
    endtask

    // Launches one request and follows it to completion and back to IDLE.
    task automatic run_fact(input logic [31:0] n, input bit drop_go,
                            input int exp_done_c, input int exp_mults,
                            input logic [31:0] exp_res, input string name);
        int done_c;
        int mults;
        @(posedge CLK);
        #1;
        GO = 1'b1;
        N  = n;
        @(posedge CLK);          // edge k
        done_c = -1;
        mults  = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                n_checks++;
                if ({CNT_LD, REG_LD, MUX, CNT_EN, DONE} !== 5'b11100 || CS !== 3'd1) begin
                    n_fail++;
                    $display("FAIL %s_load: ctrl=%b cs=%0d want ctrl=11100 cs=1",
                             name, {CNT_LD, REG_LD, MUX, CNT_EN, DONE}, CS);
                end
                if (drop_go) GO = 1'b0;
            end
            if (CNT_EN === 1'b1) begin
                mults++;
                n_checks++;
                if (MUX !== 1'b0 || REG_LD !== 1'b1 || CS !== 3'd3) begin
                    n_fail++;
                    $display("FAIL %s_mult_ctrl: mux=%b reg_ld=%b cs=%0d want 0 1 3",
                             name, MUX, REG_LD, CS);
                end
            end
            if (DONE === 1'b1) begin
                done_c = c;
                break;
            end
        end
        n_checks++;
        if (done_c != exp_done_c) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got k+%0d want k+%0d", name, done_c, exp_done_c);
        end
        n_checks++;
        if (mults != exp_mults) begin
            n_fail++;
            $display("FAIL %s_mult_count: got %0d want %0d", name, mults, exp_mults);
        end
        n_checks++;
        if (dp_reg !== exp_res || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: got %0d err=%b want %0d err=0", name, dp_reg, ERR, exp_res);
        end
        if (!drop_go) begin
            @(negedge CLK);
            n_checks++;
            if (DONE !== 1'b1 || CS !== 3'd4) begin
                n_fail++;
                $display("FAIL %s_done_hold: done=%b cs=%0d want 1 4", name, DONE, CS);
            end
            GO = 1'b0;
        end
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0 || CS !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_back_idle: done=%b cs=%0d want 0 0", name, DONE, CS);
        end
    endtask

    task automatic test_basic();
        run_fact(32'd5, 1'b0, 11, 4, 32'd120, "n5");
        run_fact(32'd0, 1'b0, 3, 0, 32'd1, "n0");
        run_fact(32'd1, 1'b0, 3, 0, 32'd1, "n1");
    endtask

    task automatic test_go_drop();
        run_fact(32'd3, 1'b1, 7, 2, 32'd6, "n3_drop");
    endtask

    task automatic test_back_to_back();
        run_fact(32'd2, 1'b1, 5, 1, 32'd2, "b2b_a");
        run_fact(32'd4, 1'b1, 9, 3, 32'd24, "b2b_b");
    endtask

    task automatic test_range();
        run_fact(32'd12, 1'b0, 25, 11, 32'd479001600, "n12");
`ifdef FACT_ERR_EN
        @(posedge CLK);
        #1;
        GO = 1'b1;
        N  = 32'd13;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (ERR !== 1'b1 || CS !== 3'd5 || CNT_LD !== 1'b0 || REG_LD !== 1'b0) begin
            n_fail++;
            $display("FAIL n13_err_entry: err=%b cs=%0d cnt_ld=%b reg_ld=%b want 1 5 0 0",
                     ERR, CS, CNT_LD, REG_LD);
        end
        @(negedge CLK);
        n_checks++;
        if (ERR !== 1'b1 || CNT_LD !== 1'b0 || REG_LD !== 1'b0) begin
            n_fail++;
            $display("FAIL n13_err_hold: err=%b cnt_ld=%b reg_ld=%b want 1 0 0", ERR, CNT_LD, REG_LD);
        end
        GO = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (ERR !== 1'b0 || CS !== 3'd0) begin
            n_fail++;
            $display("FAIL n13_err_release: err=%b cs=%0d want 0 0", ERR, CS);
        end
`else
        // 13! = 6227020800, wraps to 6227020800 - 2^32
        run_fact(32'd13, 1'b0, 27, 12, 32'd1932053504, "n13_wrap");
`endif
    endtask

    task automatic test_reset_mid();
        bit seen_mult;
        seen_mult = 1'b0;
        @(posedge CLK);
        #1;
        GO = 1'b1;
        N  = 32'd6;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (CS === 3'd3) begin
                seen_mult = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen_mult) begin
            n_fail++;
            $display("FAIL rst_mid_reach_mult: cs=%0d want 3 within 20 cycles", CS);
        end
        #2;
        RST = 1'b1;
        GO  = 1'b0;
        #1;
        n_checks++;
        if ({CNT_LD, CNT_EN, MUX, REG_LD, DONE, ERR} !== 6'b0 || CS !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: ctrl=%b cs=%0d want 000000 0",
                     {CNT_LD, CNT_EN, MUX, REG_LD, DONE, ERR}, CS);
        end
        @(negedge CLK);
        RST = 1'b0;
        run_fact(32'd4, 1'b0, 9, 3, 32'd24, "after_rst_n4");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_go_drop();
        test_back_to_back();
        test_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded 50000 time units");
        $fatal(1);
    end

endmodule
